// File: rtl/connect4_pkg.sv
// Shared constants for the 4x4 connect board: cell codes, the no-move marker,
// the table of the ten scoring lines and the board keeper FSM state codes.
package connect4_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_P1    = 2'b01;
    localparam logic [1:0] CELL_P2    = 2'b10;

    localparam logic [4:0] NO_MOVE    = 5'h1F;
    localparam logic [2:0] COL_FULL   = 3'd4;

    localparam int         NUM_LINES  = 10;
    localparam logic [3:0] LAST_LINE  = 4'd9;

    // Scan order: rows 0-3, columns 0-3, main diagonal, anti-diagonal.
    localparam logic [0:NUM_LINES-1][0:3][3:0] LINE_CELLS = {
        4'd0,  4'd1,  4'd2,  4'd3,
        4'd4,  4'd5,  4'd6,  4'd7,
        4'd8,  4'd9,  4'd10, 4'd11,
        4'd12, 4'd13, 4'd14, 4'd15,
        4'd0,  4'd4,  4'd8,  4'd12,
        4'd1,  4'd5,  4'd9,  4'd13,
        4'd2,  4'd6,  4'd10, 4'd14,
        4'd3,  4'd7,  4'd11, 4'd15,
        4'd0,  4'd5,  4'd10, 4'd15,
        4'd3,  4'd6,  4'd9,  4'd12
    };

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_SCAN    = 2'd1;
    localparam state_t ST_RELEASE = 2'd2;
    localparam state_t ST_OVER    = 2'd3;

    // Side to move after the current one.
    function automatic logic [1:0] other_player(input logic [1:0] p);
        return (p == CELL_P1) ? CELL_P2 : CELL_P1;
    endfunction

endpackage

// File: rtl/board_line_checker.sv
// Combinational test of one four-cell line against the side that just moved.
module board_line_checker
    import connect4_pkg::*;
(
    input  logic [1:0] cell_0,
    input  logic [1:0] cell_1,
    input  logic [1:0] cell_2,
    input  logic [1:0] cell_3,
    input  logic [1:0] player,
    output logic       hit
);

    // A line counts only when every cell holds the mover's (non-empty) code.
    always_comb begin
        hit = 1'b0;
        if ((player != CELL_EMPTY) && (cell_0 == player) && (cell_1 == player) &&
            (cell_2 == player) && (cell_3 == player)) begin
            hit = 1'b1;
        end else begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/board_state_keeper.sv
// Board keeper: applies accepted moves to the 4x4 board, keeps the column
// fill counters, and scans the ten lines one per cycle to detect win/draw.
module board_state_keeper
    import connect4_pkg::*;
#(
    parameter logic [1:0] START_PLAYER = 2'b01
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        new_game,
    input  logic        add,
    input  logic [4:0]  column_position,
    input  logic [1:0]  c_register,
    output logic [2:0]  counter_0,
    output logic [2:0]  counter_1,
    output logic [2:0]  counter_2,
    output logic [2:0]  counter_3,
    output logic [31:0] board,
    output logic [1:0]  player,
    output logic        busy,
    output logic        invalid,
    output logic        game_over,
    output logic [1:0]  winner
);

    state_t           state_q,     state_d;
    logic [31:0]      board_q,     board_d;
    logic [3:0][2:0]  cnt_q,       cnt_d;
    logic [1:0]       player_q,    player_d;
    logic [3:0]       line_idx_q,  line_idx_d;
    logic             hit_q,       hit_d;
    logic             busy_q,      busy_d;
    logic             invalid_q,   invalid_d;
    logic             game_over_q, game_over_d;
    logic [1:0]       winner_q,    winner_d;

    logic [0:3][3:0]  line_cells_s;
    logic             line_hit_s;
    logic [2:0]       sel_cnt_s;
    logic             move_ok_s;
    logic             all_full_s;
    logic             final_hit_s;

    // Pick the cell indices of the line being scanned this cycle.
    always_comb begin
        line_cells_s = LINE_CELLS[0];
        if (line_idx_q <= LAST_LINE) begin
            line_cells_s = LINE_CELLS[line_idx_q];
        end else begin
            line_cells_s = LINE_CELLS[0];
        end
    end

    board_line_checker u_checker (
        .cell_0 (board_q[{line_cells_s[0], 1'b0} +: 2]),
        .cell_1 (board_q[{line_cells_s[1], 1'b0} +: 2]),
        .cell_2 (board_q[{line_cells_s[2], 1'b0} +: 2]),
        .cell_3 (board_q[{line_cells_s[3], 1'b0} +: 2]),
        .player (player_q),
        .hit    (line_hit_s)
    );

    // Next-state logic: move acceptance, line scan, verdict and new_game clear.
    always_comb begin
        state_d     = state_q;
        board_d     = board_q;
        cnt_d       = cnt_q;
        player_d    = player_q;
        line_idx_d  = line_idx_q;
        hit_d       = hit_q;
        busy_d      = busy_q;
        invalid_d   = 1'b0;
        game_over_d = game_over_q;
        winner_d    = winner_q;

        sel_cnt_s   = cnt_q[c_register];
        move_ok_s   = (column_position[1:0] == c_register) &&
                      (column_position[4:2] == sel_cnt_s) &&
                      (sel_cnt_s < COL_FULL);
        all_full_s  = (cnt_q[0] == COL_FULL) && (cnt_q[1] == COL_FULL) &&
                      (cnt_q[2] == COL_FULL) && (cnt_q[3] == COL_FULL);
        final_hit_s = hit_q | line_hit_s;

        if (new_game) begin
            state_d     = ST_IDLE;
            board_d     = 32'd0;
            cnt_d       = '0;
            player_d    = START_PLAYER;
            line_idx_d  = 4'd0;
            hit_d       = 1'b0;
            busy_d      = 1'b0;
            game_over_d = 1'b0;
            winner_d    = CELL_EMPTY;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (add && (column_position != NO_MOVE)) begin
                        if (move_ok_s) begin
                            // Row bits are below 4 here, so [3:0] is the cell index.
                            board_d[{column_position[3:0], 1'b0} +: 2] = player_q;
                            cnt_d[c_register] = sel_cnt_s + 3'd1;
                            line_idx_d = 4'd0;
                            hit_d      = 1'b0;
                            busy_d     = 1'b1;
                            state_d    = ST_SCAN;
                        end else begin
                            invalid_d  = 1'b1;
                            state_d    = ST_RELEASE;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    hit_d = final_hit_s;
                    if (line_idx_q == LAST_LINE) begin
                        busy_d = 1'b0;
                        if (final_hit_s) begin
                            game_over_d = 1'b1;
                            winner_d    = player_q;
                            state_d     = ST_OVER;
                        end else if (all_full_s) begin
                            game_over_d = 1'b1;
                            winner_d    = CELL_EMPTY;
                            state_d     = ST_OVER;
                        end else begin
                            player_d    = other_player(player_q);
                            state_d     = ST_RELEASE;
                        end
                    end else begin
                        line_idx_d = line_idx_q + 4'd1;
                    end
                end
                ST_RELEASE: begin
                    if (!add) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end
                ST_OVER: begin
                    state_d = ST_OVER;
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            board_q     <= 32'd0;
            cnt_q       <= '0;
            player_q    <= START_PLAYER;
            line_idx_q  <= 4'd0;
            hit_q       <= 1'b0;
            busy_q      <= 1'b0;
            invalid_q   <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= CELL_EMPTY;
        end else begin
            state_q     <= state_d;
            board_q     <= board_d;
            cnt_q       <= cnt_d;
            player_q    <= player_d;
            line_idx_q  <= line_idx_d;
            hit_q       <= hit_d;
            busy_q      <= busy_d;
            invalid_q   <= invalid_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
        end
    end

    assign counter_0 = cnt_q[0];
    assign counter_1 = cnt_q[1];
    assign counter_2 = cnt_q[2];
    assign counter_3 = cnt_q[3];
    assign board     = board_q;
    assign player    = player_q;
    assign busy      = busy_q;
    assign invalid   = invalid_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;

endmodule

// File: tb/tb_board_state_keeper.sv
// Self-checking bench for board_state_keeper: directed table, hand sequences
// and random play, all compared against a game-level reference model.
module tb_board_state_keeper;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        new_game = 1'b0;
    logic        add = 1'b0;
    logic [4:0]  column_position = 5'd31;
    logic [1:0]  c_register = 2'd0;
    logic [2:0]  counter_0, counter_1, counter_2, counter_3;
    logic [31:0] board;
    logic [1:0]  player;
    logic        busy, invalid, game_over;
    logic [1:0]  winner;

    int n_cmp = 0;
    int n_fail = 0;

    board_state_keeper dut (
        .clk(clk), .reset(reset), .new_game(new_game), .add(add),
        .column_position(column_position), .c_register(c_register),
        .counter_0(counter_0), .counter_1(counter_1),
        .counter_2(counter_2), .counter_3(counter_3),
        .board(board), .player(player), .busy(busy), .invalid(invalid),
        .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    // Reference model: the game as plain arrays plus a countdown for the scan time.
    int mb[16];
    int mc[4];
    int mplayer, mscan, mwin;
    bit mrel, mover, minv;

    task automatic m_reset();
        for (int i = 0; i < 16; i++) mb[i] = 0;
        for (int i = 0; i < 4; i++) mc[i] = 0;
        mplayer = 1; mscan = 0; mwin = 0; mrel = 0; mover = 0; minv = 0;
    endtask

    function automatic bit m_win(int p);
        bit w = 0;
        for (int k = 0; k < 4; k++) begin
            if (mb[k*4] == p && mb[k*4+1] == p && mb[k*4+2] == p && mb[k*4+3] == p) w = 1;
            if (mb[k] == p && mb[k+4] == p && mb[k+8] == p && mb[k+12] == p) w = 1;
        end
        if (mb[0] == p && mb[5] == p && mb[10] == p && mb[15] == p) w = 1;
        if (mb[3] == p && mb[6] == p && mb[9] == p && mb[12] == p) w = 1;
        return w;
    endfunction

    task automatic m_step(bit ng, bit a, int pos, int c);
        minv = 0;
        if (ng) begin
            m_reset();
        end else if (mscan > 0) begin
            mscan--;
            if (mscan == 0) begin
                if (m_win(mplayer)) begin
                    mover = 1; mwin = mplayer;
                end else if (mc[0] == 4 && mc[1] == 4 && mc[2] == 4 && mc[3] == 4) begin
                    mover = 1; mwin = 0;
                end else begin
                    mplayer = 3 - mplayer; mrel = 1;
                end
            end
        end else if (mover) begin
            mover = 1;
        end else if (mrel) begin
            if (!a) mrel = 0;
        end else if (a && pos != 31) begin
            if (pos % 4 == c && pos / 4 == mc[c] && mc[c] < 4) begin
                mb[pos] = mplayer; mc[c]++; mscan = 10;
            end else begin
                minv = 1; mrel = 1;
            end
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        logic [31:0] eb;
        eb = 32'd0;
        for (int i = 0; i < 16; i++) eb[2*i +: 2] = 2'(mb[i]);
        chk("board", board, eb);
        chk("counters", {20'd0, counter_3, counter_2, counter_1, counter_0},
            {20'd0, 3'(mc[3]), 3'(mc[2]), 3'(mc[1]), 3'(mc[0])});
        chk("player", {30'd0, player}, 32'(mplayer));
        chk("busy", {31'd0, busy}, {31'd0, mscan > 0});
        chk("invalid", {31'd0, invalid}, {31'd0, minv});
        chk("game_over", {31'd0, game_over}, {31'd0, mover});
        chk("winner", {30'd0, winner}, 32'(mwin));
    endtask

    task automatic cycle(bit ng, bit a, int pos, int c);
        new_game = ng; add = a; column_position = 5'(pos); c_register = 2'(c);
        @(posedge clk);
        m_step(ng, a, pos, c);
        @(negedge clk);
        check_model();
    endtask

    task automatic move_and_wait(int pos);
        cycle(0, 1, pos, pos % 4);
        for (int k = 0; k < 12; k++) cycle(0, 0, 31, 0);
    endtask

    typedef struct {
        bit         a;
        logic [4:0] pos;
        logic [1:0] c;
        bit         e_busy;
        bit         e_inv;
        logic [1:0] e_player;
        logic [2:0] e_cnt0;
        logic [1:0] e_cell0;
    } vec_t;

    function automatic vec_t mkv(bit a, int pos, int c, bit eb, bit ei, int ep, int ec, int ecell);
        vec_t v;
        v.a = a; v.pos = 5'(pos); v.c = 2'(c); v.e_busy = eb; v.e_inv = ei;
        v.e_player = 2'(ep); v.e_cnt0 = 3'(ec); v.e_cell0 = 2'(ecell);
        return v;
    endfunction

    vec_t vt[19];

    initial begin
        int drawseq[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 9, 8, 11, 10, 13, 12, 15, 14};
        int winseq[7]   = '{0, 4, 1, 5, 2, 6, 3};

        vt[0] = mkv(1, 0, 0, 1, 0, 1, 1, 1);
        for (int i = 1; i <= 9; i++) vt[i] = mkv(0, 31, 0, 1, 0, 1, 1, 1);
        vt[10] = mkv(0, 31, 0, 0, 0, 2, 1, 1);
        vt[11] = mkv(0, 31, 0, 0, 0, 2, 1, 1);
        vt[12] = mkv(1, 5, 0, 0, 1, 2, 1, 1);
        vt[13] = mkv(0, 31, 0, 0, 0, 2, 1, 1);
        vt[14] = mkv(1, 8, 0, 0, 1, 2, 1, 1);
        vt[15] = mkv(0, 31, 0, 0, 0, 2, 1, 1);
        vt[16] = mkv(1, 31, 0, 0, 0, 2, 1, 1);
        vt[17] = mkv(0, 31, 0, 0, 0, 2, 1, 1);
        vt[18] = mkv(1, 4, 0, 1, 0, 2, 2, 1);

        // Reset state.
        m_reset();
        repeat (2) @(negedge clk);
        check_model();
        reset = 1'b0;

        // Directed table: first move, scan length, rejected and ignored requests.
        for (int i = 0; i < 19; i++) begin
            cycle(0, vt[i].a, vt[i].pos, vt[i].c);
            chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vt[i].e_busy});
            chk($sformatf("vec%0d_invalid", i), {31'd0, invalid}, {31'd0, vt[i].e_inv});
            chk($sformatf("vec%0d_player", i), {30'd0, player}, {30'd0, vt[i].e_player});
            chk($sformatf("vec%0d_cnt0", i), {29'd0, counter_0}, {29'd0, vt[i].e_cnt0});
            chk($sformatf("vec%0d_cell0", i), {30'd0, board[1:0]}, {30'd0, vt[i].e_cell0});
        end

        // Held add applies exactly one move; the next one needs add to drop.
        cycle(1, 0, 31, 0);
        for (int k = 0; k < 30; k++) cycle(0, 1, 0, 0);
        chk("held_add_cnt0", {29'd0, counter_0}, 32'd1);
        cycle(0, 0, 31, 0);
        cycle(0, 1, 4, 0);
        chk("second_move_cnt0", {29'd0, counter_0}, 32'd2);
        for (int k = 0; k < 12; k++) cycle(0, 0, 31, 0);

        // P1 completes row 0.
        cycle(1, 0, 31, 0);
        foreach (winseq[i]) move_and_wait(winseq[i]);
        chk("row_win_over", {31'd0, game_over}, 32'd1);
        chk("row_win_winner", {30'd0, winner}, 32'd1);
        for (int k = 0; k < 4; k++) cycle(0, 1, 7, 3);
        chk("over_no_invalid", {31'd0, invalid}, 32'd0);

        // Full board without a line: draw.
        cycle(1, 0, 31, 0);
        foreach (drawseq[i]) move_and_wait(drawseq[i]);
        chk("draw_over", {31'd0, game_over}, 32'd1);
        chk("draw_winner", {30'd0, winner}, 32'd0);
        chk("draw_counters", {20'd0, counter_3, counter_2, counter_1, counter_0}, 32'h924);
        cycle(0, 1, 16, 0);

        // Asynchronous reset in the middle of a scan.
        cycle(1, 0, 31, 0);
        cycle(0, 1, 0, 0);
        for (int k = 0; k < 5; k++) cycle(0, 0, 31, 0);
        reset = 1'b1;
        #2;
        m_reset();
        check_model();
        #1 reset = 1'b0;
        cycle(0, 1, 1, 1);
        chk("after_reset_cnt1", {29'd0, counter_1}, 32'd1);
        for (int k = 0; k < 12; k++) cycle(0, 0, 31, 0);

        // Random play against the model.
        for (int n = 0; n < 3000; n++) begin
            int c, pos;
            bit a, ng;
            c   = $urandom_range(0, 3);
            pos = ($urandom_range(0, 1) == 1) ? (mc[c] * 4 + c) : $urandom_range(0, 31);
            a   = ($urandom_range(0, 2) != 0);
            ng  = ($urandom_range(0, 299) == 0) || (mover && $urandom_range(0, 19) == 0);
            cycle(ng, a, pos, c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
